data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Multi-cycle data-memory responder: the target end of the CPU load/store interface.
//   Accepts one word request at a time over a valid/ready handshake, waits LATENCY cycles,
//   then commits the write or returns the read data with a one-cycle response pulse.
//   Sits between the CPU data port (address = ALU result, wdata = rs2) and word storage.
//   Replaces the zero-latency data memory when the pipeline must tolerate stalls.
// PARAMETERS
//   DEPTH    256  storage size in 32-bit words; power of 2; ADDR_W = $clog2(DEPTH)
//   LATENCY  2    cycles from accepting edge to rsp_valid edge; >= 1, 0 is an elaboration error
// PORTS
//   clk        in   1   clock, all state updates on rising edge
//   rst        in   1   asynchronous reset, active-low
//   req_valid  in   1   request present; initiator holds all req_* stable until accepted
//   req_ready  out  1   responder can accept a request this cycle
//   req_write  in   1   1 = store word, 0 = load word
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data
//   rsp_valid  out  1   single-cycle pulse: transaction complete
//   rsp_rdata  out  32  load data; valid with rsp_valid, held until next response
//   rsp_err    out  1   only with DMEM_ERR_EN: transaction rejected, valid with rsp_valid
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0,
//     rsp_err=0, every storage word cleared to 0. req_ready rises the first cycle after release.
//   States: IDLE, BUSY, RESP.
//     IDLE: req_ready=1. Accept on edge with req_valid&&req_ready: latch write/addr/wdata,
//       cnt<=LATENCY-1; go RESP when LATENCY==1, else BUSY.
//     BUSY: req_ready=0; req_valid is ignored. cnt decrements each edge; at cnt==1 go RESP.
//     RESP: rsp_valid=1 for exactly this cycle. On the edge entering RESP, a store writes
//       storage and a load loads rsp_rdata. req_ready=1 in RESP; an accept here goes to
//       BUSY/RESP as from IDLE (back-to-back). No accept -> IDLE.
//   Latency: rsp_valid rises exactly LATENCY edges after the accepting edge.
//     Peak throughput is one request per LATENCY+1 cycles... except back-to-back from RESP gives
//     one per LATENCY cycles.
//   Index: word = addr_q[ADDR_W+1:2]; addr_q[1:0] and bits above ADDR_W+1 are ignored
//     (wrap-around aliasing) unless DMEM_ERR_EN.
//   Store response: rsp_rdata <= 0. A load from a word stored earlier returns the stored value.
//   No backpressure on response: the initiator must sample rsp_* in the rsp_valid cycle.
//   Reset mid-transaction: transaction dropped, no storage write, no rsp_valid pulse.
//   A store commits only in RESP, so a load issued after its response sees the new data.
// CONFIGURATION
//   DMEM_ERR_EN defined: rsp_err port exists. Error when addr_q[1:0]!=0 or addr_q >= 4*DEPTH.
//     On error: rsp_err=1 in the RESP cycle, store suppressed, rsp_rdata <= 0, and latency unchanged.
//     rsp_err=0 for good responses.
//   DMEM_ERR_EN undefined: no rsp_err port; misaligned and out-of-range addresses alias as above.
// TESTING
//   1 Reset: rst=0 with req_valid=1 -> req_ready=0, rsp_valid=0; after release read addr 0x40
//     -> rsp_rdata=0.
//   2 Store then load, LATENCY=2: write 0xDEADBEEF @0x10 -> rsp_valid 2 edges after accept.
//     Then read @0x10 -> rsp_rdata=0xDEADBEEF 2 edges after accept.
//   3 Back-to-back: req_valid held high for read @0x10 then read @0x14 -> second accepted in
//     RESP cycle; rsp pulses 2 cycles apart; req_valid during BUSY produces no extra accept.
//   4 LATENCY=1: store 0x5 @0x8 -> rsp_valid the cycle after accept; load @0x8 returns 0x5.
//   5 Reset mid-op: accept store 0x1234 @0x20, drop rst in BUSY -> no rsp_valid; load @0x20
//     -> 0.
//   6 DMEM_ERR_EN, DEPTH=256: store 0x1 @0x402 and @0x400 -> rsp_err=1 both, no write.
//     Without macro, @0x400 aliases word 0: load @0x0 -> 0x1.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle word data-memory responder (optional DMEM_ERR_EN address checking)
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata
`ifdef DMEM_ERR_EN
    ,
    output logic        rsp_err
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("data_mem_responder: LATENCY must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_en_q;
    logic               write_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               err_q;
    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               commit;
    logic               c_write;
    logic [31:0]        c_addr;
    logic [31:0]        c_wdata;
    logic [ADDR_W-1:0]  c_index;
    logic               c_err;

    // Ready only once out of reset, and only in states that may take a new request.
    assign req_ready = ready_en_q && (state_q == IDLE || state_q == RESP);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);

    // With LATENCY==1 the transaction commits on its own accepting edge, so use the live request.
    assign c_write = (state_q == BUSY) ? write_q : req_write;
    assign c_addr  = (state_q == BUSY) ? addr_q  : req_addr;
    assign c_wdata = (state_q == BUSY) ? wdata_q : req_wdata;
    assign c_index = c_addr[ADDR_W+1:2];
    assign commit  = (state_d == RESP);

`ifdef DMEM_ERR_EN
    assign c_err   = (c_addr[1:0] != 2'b00) || (c_addr >= 32'(4 * DEPTH));
    assign rsp_err = rsp_valid && err_q;
`else
    assign c_err   = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, c_addr[31:ADDR_W+2], c_addr[1:0], err_q};
`endif

    // Next-state logic for the IDLE/BUSY/RESP handshake sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (LATENCY == 1) ? RESP : BUSY;
            BUSY: if (cnt_q == CNT_W'(1)) state_d = RESP;
            RESP: begin
                if (accept) state_d = (LATENCY == 1) ? RESP : BUSY;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers: state, latency counter, request latch and response data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt_q   <= CNT_W'(LATENCY - 1);
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (commit) begin
                err_q     <= c_err;
                rsp_rdata <= (c_write || c_err) ? 32'h0 : mem[c_index];
            end
        end
    end

    // Word storage: cleared by reset, a good store commits on the edge entering RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit && c_write && !c_err) begin
            mem[c_index] <= c_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder (LATENCY 2 and 1 instances)
module tb_data_mem_responder;

    localparam int DEPTH = 256;
`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int          lat_of [2] = '{2, 1};
    logic [31:0] model [2][DEPTH];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0])
`ifdef DMEM_ERR_EN
        , .rsp_err(rsp_err[0])
`endif
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1])
`ifdef DMEM_ERR_EN
        , .rsp_err(rsp_err[1])
`endif
    );

`ifndef DMEM_ERR_EN
    assign rsp_err[0] = 1'b0;
    assign rsp_err[1] = 1'b0;
`endif

    typedef struct {
        int          d;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) model[d][i] = 32'h0;
    endtask

    // Reference: word-addressed storage, modulo aliasing, optional range/alignment rejection.
    task automatic model_txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er);
        int idx;
        er  = ERR_EN && ((a % 4) != 0 || a >= 32'(4 * DEPTH));
        idx = int'((a / 4) % DEPTH);
        rd  = 32'h0;
        if (!er) begin
            if (w) model[d][idx] = wd;
            else   rd = model[d][idx];
        end
    endtask

    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_er, input string name);
        bit got_ready;
        int lat;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = w;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        got_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready[d]) begin
                got_ready = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check32({name, " ready"}, 32'(got_ready), 32'd1);
        if (!got_ready) begin
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) req_valid[d] = 1'b0;
            if (rsp_valid[d]) begin
                lat = i;
                break;
            end
        end
        check32({name, " latency"}, 32'(lat), 32'(lat_of[d]));
        check32({name, " rdata"}, rsp_rdata[d], exp_rd);
        check32({name, " err"}, 32'(rsp_err[d]), 32'(exp_er));
    endtask

    task automatic model_and_txn(input int d, input logic w, input logic [31:0] a,
                                 input logic [31:0] wd, input string name);
        logic [31:0] rd;
        logic        er;
        model_txn(d, w, a, wd, rd, er);
        txn(d, w, a, wd, rd, er, name);
    endtask

    initial begin
        vec_t        vecs [7];
        logic [31:0] e1, e2, rd;
        logic        er;

        vecs[0] = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF};
        vecs[2] = '{1, 1'b1, 32'h8,   32'h5,        32'h0};
        vecs[3] = '{1, 1'b0, 32'h8,   32'h0,        32'h5};
        vecs[4] = '{0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 32'h0};
        vecs[5] = '{0, 1'b0, 32'h3FC, 32'h0,        32'hA5A5A5A5};
        vecs[6] = '{1, 1'b0, 32'h0,   32'h0,        32'h0};

        clear_model();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b1;
            req_write[d] = 1'b0;
            req_addr[d]  = 32'h40;
            req_wdata[d] = 32'h0;
        end

        // Reset state while a request is being offered.
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check32("reset req_ready", 32'(req_ready[d]), 32'd0);
            check32("reset rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check32("reset rsp_rdata", rsp_rdata[d], 32'h0);
            check32("reset rsp_err", 32'(rsp_err[d]), 32'd0);
            req_valid[d] = 1'b0;
        end
        rst = 1'b1;
        model_and_txn(0, 1'b0, 32'h40, 32'h0, "reset load L2");
        model_and_txn(1, 1'b0, 32'h40, 32'h0, "reset load L1");

        // Table of directed stores/loads with hand-computed expectations.
        for (int i = 0; i < 7; i++) begin
            model_txn(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, rd, er);
            txn(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].exp_rd, 1'b0,
                $sformatf("vec%0d", i));
        end

        // Back-to-back reads: second request accepted in the RESP cycle, BUSY ignores req_valid.
        model_txn(0, 1'b0, 32'h10, 32'h0, e1, er);
        model_txn(0, 1'b0, 32'h14, 32'h0, e2, er);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h10;
        check32("b2b first ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        check32("b2b busy ready", 32'(req_ready[0]), 32'd0);
        check32("b2b busy rsp_valid", 32'(rsp_valid[0]), 32'd0);
        req_addr[0] = 32'h14;
        @(negedge clk);
        check32("b2b rsp1 valid", 32'(rsp_valid[0]), 32'd1);
        check32("b2b rsp1 rdata", rsp_rdata[0], e1);
        check32("b2b resp ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        check32("b2b gap rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check32("b2b second busy ready", 32'(req_ready[0]), 32'd0);
        req_valid[0] = 1'b0;
        @(negedge clk);
        check32("b2b rsp2 valid", 32'(rsp_valid[0]), 32'd1);
        check32("b2b rsp2 rdata", rsp_rdata[0], e2);
        @(negedge clk);
        check32("b2b no extra rsp", 32'(rsp_valid[0]), 32'd0);

        // Misaligned / out-of-range stores: rejected with the macro, aliased to word 0 without.
        model_txn(0, 1'b1, 32'h402, 32'h1, rd, er);
        txn(0, 1'b1, 32'h402, 32'h1, 32'h0, ERR_EN, "oob store 0x402");
        model_txn(0, 1'b1, 32'h400, 32'h1, rd, er);
        txn(0, 1'b1, 32'h400, 32'h1, 32'h0, ERR_EN, "oob store 0x400");
        model_txn(0, 1'b0, 32'h0, 32'h0, rd, er);
        txn(0, 1'b0, 32'h0, 32'h0, ERR_EN ? 32'h0 : 32'h1, 1'b0, "alias load 0x0");

        // Reset during BUSY drops the store and the response.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h1234;
        check32("midrst ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check32("midrst rsp_valid", 32'(rsp_valid[0]), 32'd0);
            @(negedge clk);
        end
        rst = 1'b1;
        clear_model();
        model_and_txn(0, 1'b0, 32'h20, 32'h0, "midrst load 0x20");

        // Random traffic on both instances against the reference model.
        for (int n = 0; n < 160; n++) begin
            int          d;
            logic        w;
            logic [31:0] a;
            d = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 7) == 0) a = a + 32'h400;
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            model_and_txn(d, w, a, $urandom, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
